// File: rtl/pivot_search.sv
// pivot_search: sequential largest-|a_ij| finder over the strict upper triangle
// of an N_STOCKS x N_STOCKS signed matrix held in an external synchronous RAM.
//
// Ports:
//   clk_in, rst_in     clock, synchronous active-high reset
//   start, threshold   scan request (taken only in IDLE) and unsigned threshold
//   rd_addr, rd_en     RAM read request, row-major address i*N_STOCKS+j
//   rd_data            signed RAM data, READ_LATENCY cycles after the request
//   busy, done         scan in progress / one-cycle completion pulse
//   pivot_i, pivot_j   pivot position (pivot_i < pivot_j)
//   pivot_mag          saturated |a_ij| of the pivot
//   converged          pivot_mag <= captured threshold
module pivot_search #(
  parameter  int WIDTH        = 16,
  parameter  int N_STOCKS     = 4,
  parameter  int READ_LATENCY = 2,
  localparam int IDX_W        = (N_STOCKS > 2) ? $clog2(N_STOCKS) : 1,
  localparam int ADDR_W       = $clog2(N_STOCKS * N_STOCKS)
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     start,
  input  logic [WIDTH-1:0]         threshold,
  output logic [ADDR_W-1:0]        rd_addr,
  output logic                     rd_en,
  input  logic signed [WIDTH-1:0]  rd_data,
  output logic                     busy,
  output logic                     done,
  output logic [IDX_W-1:0]         pivot_i,
  output logic [IDX_W-1:0]         pivot_j,
  output logic [WIDTH-1:0]         pivot_mag,
  output logic                     converged
);

  // vld_pipe[STAGES] lines up with rd_data for the matching request
  localparam int STAGES = READ_LATENCY - 1;
  localparam logic [ADDR_W-1:0] N_A      = ADDR_W'(N_STOCKS);
  localparam logic [WIDTH-1:0]  MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0]  MAX_POS  = {1'b0, {(WIDTH-1){1'b1}}};

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t state, nxt_state;

  logic [IDX_W-1:0] cur_i, cur_j;
  logic [WIDTH-1:0] thr_q;
  logic [2:0]       drain_cnt;
  logic             last_pair, drain_last, accept;

  assign last_pair  = (cur_i == IDX_W'(N_STOCKS - 2)) && (cur_j == IDX_W'(N_STOCKS - 1));
  assign drain_last = (drain_cnt == 3'(READ_LATENCY - 1));
  assign accept     = (state == IDLE) && start;

  // ---------------- FSM ----------------
  always_ff @(posedge clk_in) begin
    if (rst_in) state <= IDLE;
    else        state <= nxt_state;
  end

  always_comb begin
    nxt_state = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:  if (start) nxt_state = ISSUE;
      ISSUE: begin
        busy = 1'b1;
        if (last_pair) nxt_state = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (drain_last) nxt_state = DONE;
      end
      DONE: begin
        done      = 1'b1;
        nxt_state = IDLE;
      end
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in || state != DRAIN) drain_cnt <= '0;
    else                          drain_cnt <= drain_cnt + 3'd1;
  end

  // ---------------- request generator ----------------
  // cur_i/cur_j always name the pair currently on rd_addr.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rd_en   <= 1'b0;
      rd_addr <= '0;
      cur_i   <= '0;
      cur_j   <= IDX_W'(1);
      thr_q   <= '0;
    end else if (accept) begin
      rd_en   <= 1'b1;
      rd_addr <= ADDR_W'(1);
      cur_i   <= '0;
      cur_j   <= IDX_W'(1);
      thr_q   <= threshold;
    end else if (state == ISSUE) begin
      if (last_pair) begin
        rd_en <= 1'b0;
      end else if (cur_j == IDX_W'(N_STOCKS - 1)) begin
        // next row starts just right of the diagonal
        cur_i   <= cur_i + IDX_W'(1);
        cur_j   <= cur_i + IDX_W'(1) + IDX_W'(1);
        rd_addr <= (ADDR_W'(cur_i) + ADDR_W'(1)) * N_A + ADDR_W'(cur_i) + ADDR_W'(2);
      end else begin
        cur_j   <= cur_j + IDX_W'(1);
        rd_addr <= rd_addr + ADDR_W'(1);
      end
    end
  end

  // ---------------- delay line ----------------
  logic [STAGES:0]            vld_pipe;
  logic [STAGES:0][IDX_W-1:0] i_pipe, j_pipe;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      vld_pipe <= '0;
      i_pipe   <= '0;
      j_pipe   <= '0;
    end else begin
      vld_pipe[0] <= rd_en;
      i_pipe[0]   <= cur_i;
      j_pipe[0]   <= cur_j;
      for (int s = 1; s <= STAGES; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        i_pipe[s]   <= i_pipe[s-1];
        j_pipe[s]   <= j_pipe[s-1];
      end
    end
  end

  // ---------------- magnitude + running max ----------------
  logic [WIDTH-1:0] raw, in_mag;
  logic [WIDTH-1:0] max_mag, nxt_mag;
  logic [IDX_W-1:0] max_i, max_j, nxt_i, nxt_j;
  logic             have;

  assign raw = rd_data;

  always_comb begin
    in_mag = raw;
    if (raw == MOST_NEG)    in_mag = MAX_POS;
    else if (raw[WIDTH-1])  in_mag = ~raw + WIDTH'(1);
  end

  // strict '>' keeps the earliest element on ties
  always_comb begin
    nxt_mag = max_mag;
    nxt_i   = max_i;
    nxt_j   = max_j;
    if (vld_pipe[STAGES] && (!have || in_mag > max_mag)) begin
      nxt_mag = in_mag;
      nxt_i   = i_pipe[STAGES];
      nxt_j   = j_pipe[STAGES];
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      have    <= 1'b0;
      max_mag <= '0;
      max_i   <= '0;
      max_j   <= '0;
    end else if (accept) begin
      have <= 1'b0;
    end else if (vld_pipe[STAGES]) begin
      have    <= 1'b1;
      max_mag <= nxt_mag;
      max_i   <= nxt_i;
      max_j   <= nxt_j;
    end
  end

  // ---------------- results ----------------
  // Loaded on the edge of the final compare so they are valid with done.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pivot_i   <= '0;
      pivot_j   <= IDX_W'(1);
      pivot_mag <= '0;
      converged <= 1'b0;
    end else if (state == DRAIN && drain_last) begin
      pivot_i   <= nxt_i;
      pivot_j   <= nxt_j;
      pivot_mag <= nxt_mag;
      converged <= (nxt_mag <= thr_q);
    end
  end

endmodule

// File: tb/tb_pivot_search.sv
// Scoreboard bench for pivot_search: instance A (N=4, latency 2) takes directed
// and random scans, instance B (N=8, latency 1) takes 500 random scans.
module tb_pivot_search;
  logic clk_in = 1'b0;
  logic rst_in;
  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int errors = 0, checks = 0;

  // ---------------- instance A ----------------
  logic               start_a, en_a, busy_a, done_a, conv_a;
  logic [15:0]        thr_a, mag_a;
  logic [3:0]         addr_a;
  logic signed [15:0] data_a, a_d1, a_d2;
  logic [1:0]         pi_a, pj_a;
  logic signed [15:0] mem_a [16];

  pivot_search #(.WIDTH(16), .N_STOCKS(4), .READ_LATENCY(2)) dut_a (
    .clk_in(clk_in), .rst_in(rst_in), .start(start_a), .threshold(thr_a),
    .rd_addr(addr_a), .rd_en(en_a), .rd_data(data_a), .busy(busy_a), .done(done_a),
    .pivot_i(pi_a), .pivot_j(pj_a), .pivot_mag(mag_a), .converged(conv_a));

  always @(posedge clk_in) begin
    if (en_a) a_d1 <= mem_a[addr_a];
    a_d2 <= a_d1;
  end
  assign data_a = a_d2;

  // ---------------- instance B ----------------
  logic               start_b, en_b, busy_b, done_b, conv_b;
  logic [15:0]        thr_b, mag_b;
  logic [5:0]         addr_b;
  logic signed [15:0] data_b, b_d1;
  logic [2:0]         pi_b, pj_b;
  logic signed [15:0] mem_b [64];

  pivot_search #(.WIDTH(16), .N_STOCKS(8), .READ_LATENCY(1)) dut_b (
    .clk_in(clk_in), .rst_in(rst_in), .start(start_b), .threshold(thr_b),
    .rd_addr(addr_b), .rd_en(en_b), .rd_data(data_b), .busy(busy_b), .done(done_b),
    .pivot_i(pi_b), .pivot_j(pj_b), .pivot_mag(mag_b), .converged(conv_b));

  always @(posedge clk_in) if (en_b) b_d1 <= mem_b[addr_b];
  assign data_b = b_d1;

  // ---------------- scoreboard ----------------
  typedef struct { int i; int j; int mag; int conv; int cyc; } exp_t;
  exp_t qa[$], qb[$];
  exp_t ea, eb, prev_a;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk_in) begin
    if (en_a) chk("a_upper_tri", int'(addr_a / 4 < addr_a % 4), 1);
    if (done_a) begin
      if (qa.size() == 0) chk("a_unexpected_done", 1, 0);
      else begin
        ea = qa.pop_front();
        chk("a_done_cycle", cyc, ea.cyc);
        chk("a_pivot_i", int'(pi_a), ea.i);
        chk("a_pivot_j", int'(pj_a), ea.j);
        chk("a_pivot_mag", int'(mag_a), ea.mag);
        chk("a_converged", int'(conv_a), ea.conv);
      end
    end
  end

  always @(negedge clk_in) begin
    if (en_b) chk("b_upper_tri", int'(addr_b / 8 < addr_b % 8), 1);
    if (done_b) begin
      if (qb.size() == 0) chk("b_unexpected_done", 1, 0);
      else begin
        eb = qb.pop_front();
        chk("b_done_cycle", cyc, eb.cyc);
        chk("b_pivot_i", int'(pi_b), eb.i);
        chk("b_pivot_j", int'(pj_b), eb.j);
        chk("b_pivot_mag", int'(mag_b), eb.mag);
        chk("b_converged", int'(conv_b), eb.conv);
      end
    end
  end

  // ---------------- reference model ----------------
  int mm [64];   // row-major matrix for the scan being prepared

  function automatic exp_t model(input int n, input int thr);
    exp_t r;
    int best = -1;
    r.i = 0; r.j = 1; r.cyc = 0;
    for (int i = 0; i < n; i++)
      for (int j = i + 1; j < n; j++) begin
        int v = mm[i*n + j];
        int m = (v < 0) ? -v : v;
        if (m > 32767) m = 32767;
        if (m > best) begin best = m; r.i = i; r.j = j; end
      end
    r.mag  = best;
    r.conv = int'(best <= thr);
    return r;
  endfunction

  function automatic int gen();
    case ($urandom_range(0, 7))
      0: return -32768;
      1: return 32767;
      2: return -32767;
      3: return int'($urandom_range(0, 10)) - 5;
      default: return int'($urandom_range(0, 65535)) - 32768;
    endcase
  endfunction

  task automatic fill_rand(input int n);
    for (int i = 0; i < n; i++)
      for (int j = i; j < n; j++) begin
        int v = gen();
        mm[i*n + j] = v;
        mm[j*n + i] = v;
      end
  endtask

  task automatic set_tri4(input int v01, v02, v03, v12, v13, v23);
    int t[6];
    int k = 0;
    t = '{v01, v02, v03, v12, v13, v23};
    for (int i = 0; i < 4; i++) begin
      mm[i*4 + i] = 20000;     // diagonal is never read; a large value exposes it
      for (int j = i + 1; j < 4; j++) begin
        mm[i*4 + j] = t[k];
        mm[j*4 + i] = t[k];
        k++;
      end
    end
  endtask

  task automatic load_a();
    for (int k = 0; k < 16; k++) mem_a[k] = 16'(mm[k]);
  endtask

  task automatic load_b();
    for (int k = 0; k < 64; k++) mem_b[k] = 16'(mm[k]);
  endtask

  // One scan on A. pulse_at: cycle of an extra start pulse (0 = none).
  // rst_at: cycle in which rst_in is held high (0 = none).
  task automatic scan_a(input int thr, input exp_t e, input int pulse_at, input int rst_at);
    int base;
    int adr4[6];
    bit aborted;
    adr4 = '{1, 2, 3, 6, 7, 11};
    @(negedge clk_in);
    thr_a = 16'(thr); start_a = 1'b1; base = cyc;
    if (rst_at == 0) begin
      e.cyc = base + 9;
      qa.push_back(e);
    end
    for (int n = 1; n <= 11; n++) begin
      @(negedge clk_in);
      aborted = (rst_at != 0) && (n > rst_at);
      if (n == 1) start_a = 1'b0;
      thr_a = 16'($urandom_range(0, 65535));   // must not affect this scan
      chk("a_rd_en", int'(en_a), int'(!aborted && n <= 6));
      if (!aborted && n <= 6) chk("a_rd_addr", int'(addr_a), adr4[n-1]);
      chk("a_busy", int'(busy_a), int'(!aborted && n <= 8));
      if (n == 3) begin
        chk("a_hold_i", int'(pi_a), prev_a.i);
        chk("a_hold_j", int'(pj_a), prev_a.j);
        chk("a_hold_mag", int'(mag_a), prev_a.mag);
      end
      if (aborted && n == rst_at + 1) begin
        chk("a_rst_done", int'(done_a), 0);
        chk("a_rst_i", int'(pi_a), 0);
        chk("a_rst_j", int'(pj_a), 1);
        chk("a_rst_mag", int'(mag_a), 0);
        chk("a_rst_conv", int'(conv_a), 0);
      end
      if (n == pulse_at) start_a = 1'b1;
      if (n == pulse_at + 1 && pulse_at != 0) start_a = 1'b0;
      if (n == rst_at) rst_in = 1'b1;
      if (n == rst_at + 1 && rst_at != 0) rst_in = 1'b0;
    end
    if (rst_at == 0) prev_a = e;
    else prev_a = '{0, 1, 0, 0, 0};
  endtask

  exp_t e;
  int   thr;
  int   base;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_in = 1'b1; start_a = 1'b0; start_b = 1'b0; thr_a = '0; thr_b = '0;
    a_d1 = '0; a_d2 = '0; b_d1 = '0;
    for (int k = 0; k < 16; k++) mem_a[k] = '0;
    for (int k = 0; k < 64; k++) mem_b[k] = '0;
    prev_a = '{0, 1, 0, 0, 0};
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;

    chk("rst_busy", int'(busy_a), 0);
    chk("rst_done", int'(done_a), 0);
    chk("rst_rd_en", int'(en_a), 0);
    chk("rst_rd_addr", int'(addr_a), 0);
    chk("rst_pivot_i", int'(pi_a), 0);
    chk("rst_pivot_j", int'(pj_a), 1);
    chk("rst_pivot_mag", int'(mag_a), 0);
    chk("rst_converged", int'(conv_a), 0);
    chk("rst_b_pivot_j", int'(pj_b), 1);

    // basic scan
    set_tri4(3, -9, 5, 7, -2, 1); load_a();
    scan_a(4, '{0, 2, 9, 0, 0}, 0, 0);
    // ties keep first element, threshold inclusive
    set_tri4(-6, -6, -6, -6, -6, -6); load_a();
    scan_a(6, '{0, 1, 6, 1, 0}, 0, 0);
    // most-negative saturates then ties with the first 32767
    set_tri4(32767, 32767, 32767, 32767, -32768, 32767); load_a();
    scan_a(0, '{0, 1, 32767, 0, 0}, 0, 0);
    // start pulse mid-scan is ignored
    set_tri4(3, -9, 5, 7, -2, 1); load_a();
    scan_a(4, '{0, 2, 9, 0, 0}, 4, 0);
    // reset mid-scan aborts; next scan is clean
    scan_a(4, '{0, 2, 9, 0, 0}, 0, 5);
    scan_a(9, '{0, 2, 9, 1, 0}, 0, 0);

    // reset and start together: reset wins
    @(negedge clk_in); rst_in = 1'b1; start_a = 1'b1;
    @(negedge clk_in); rst_in = 1'b0; start_a = 1'b0;
    chk("rst_start_busy", int'(busy_a), 0);
    chk("rst_start_rd_en", int'(en_a), 0);
    @(negedge clk_in);
    chk("rst_start_busy2", int'(busy_a), 0);
    prev_a = '{0, 1, 0, 0, 0};

    // random scans on A
    for (int s = 0; s < 20; s++) begin
      fill_rand(4); load_a();
      e = model(4, 0);
      thr = ($urandom_range(0, 1) == 0) ? e.mag : int'($urandom_range(0, 32767));
      e = model(4, thr);
      scan_a(thr, e, 0, 0);
    end

    // 500 random scans on B, back to back with the minimum gap
    for (int s = 0; s < 500; s++) begin
      fill_rand(8); load_b();
      e = model(8, 0);
      case ($urandom_range(0, 3))
        0: thr = e.mag;
        1: thr = e.mag - 1;
        default: thr = int'($urandom_range(0, 32767));
      endcase
      if (thr < 0) thr = 0;
      e = model(8, thr);
      @(negedge clk_in);
      thr_b = 16'(thr); start_b = 1'b1; base = cyc;
      e.cyc = base + 30;
      qb.push_back(e);
      @(negedge clk_in); start_b = 1'b0;
      repeat (29) begin
        @(negedge clk_in);
        thr_b = 16'($urandom_range(0, 65535));
      end
      // a start held through DONE is ignored there and taken in IDLE
      if (s < 499 && $urandom_range(0, 1) == 1) start_b = 1'b1;
    end

    repeat (5) @(negedge clk_in);
    chk("a_queue_empty", qa.size(), 0);
    chk("b_queue_empty", qb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
